// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, the register word type and the
// address-width helper used wherever a register index is sized.
package cpu_pkg;

  // Index width for n entries; never below one bit so a single-entry file still has a port.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = addr_width(NUM_REGS);

  typedef logic [DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_wdec.sv
// Write-address decoder for the register file: turns a binary write address into a one-hot
// per-register write strobe, all strobes low when the write enable is low. An address with no
// matching register (>= NumRegs) produces no strobe, so such writes fall on the floor.
//
// Ports:
//   we_i      write enable
//   addr_i    binary write address
//   onehot_o  per-register write strobe, bit i selects register i
module regfile_wdec
  import cpu_pkg::*;
#(
  parameter int unsigned NumRegs = NUM_REGS,
  parameter int unsigned AddrW   = addr_width(NumRegs)
) (
  input  logic               we_i,
  input  logic [AddrW-1:0]   addr_i,
  output logic [NumRegs-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (we_i && (addr_i == AddrW'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with registered read ports and a flat view of every
// register for a downstream select mux.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset; clears registers and read data
//   we         write enable
//   waddr      write address
//   wdata      write data
//   raddr1/2   read addresses
//   rdata1/2   read data, one-cycle latency, a same-edge write to the read address is forwarded
//   regs_flat  all registers, bits [DATA_W*i +: DATA_W] hold register i
//
// Build option: define REG0_ZERO_EN to hardwire register 0 to zero (writes discarded, reads and
// the flat slice always zero, no forwarding). Undefined, register 0 is an ordinary register.
module register_file
  import cpu_pkg::addr_width;
#(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
  localparam int unsigned ADDR_W  = addr_width(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [ADDR_W-1:0]          raddr1,
  input  logic [ADDR_W-1:0]          raddr2,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  // The address space is padded to a power of two so any read address indexes a defined slot;
  // slots without a register read as zero and never take a write strobe.
  localparam int unsigned NumSlots = 1 << ADDR_W;

`ifdef REG0_ZERO_EN
  localparam bit Reg0Zero = 1'b1;
`else
  localparam bit Reg0Zero = 1'b0;
`endif

  logic [NUM_REGS-1:0] wen_oh;
  logic [NumSlots-1:0] wen_ext;
  logic [DATA_W-1:0]   regs_ext [NumSlots];

  logic [DATA_W-1:0] rdata1_d, rdata1_q;
  logic [DATA_W-1:0] rdata2_d, rdata2_q;

  regfile_wdec #(
    .NumRegs (NUM_REGS),
    .AddrW   (ADDR_W)
  ) u_wdec (
    .we_i     (we),
    .addr_i   (waddr),
    .onehot_o (wen_oh)
  );

  // Storage: one flop bank per real register; hardwired and padding slots are constant zero.
  for (genvar i = 0; i < NumSlots; i++) begin : g_slot
    if ((i >= NUM_REGS) || ((i == 0) && Reg0Zero)) begin : g_const
      assign wen_ext[i]  = 1'b0;
      assign regs_ext[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= '0;
        end else if (wen_oh[i]) begin
          word_q <= wdata;
        end
      end

      assign wen_ext[i]  = wen_oh[i];
      assign regs_ext[i] = word_q;
    end
  end

`ifdef REG0_ZERO_EN
  // Register 0 has no storage, so its write strobe goes nowhere.
  logic unused_wen0;
  assign unused_wen0 = wen_oh[0];
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[DATA_W*i +: DATA_W] = regs_ext[i];
  end

  // Read next-state: a write landing on the read address this edge wins over the stored word.
  always_comb begin
    rdata1_d = wen_ext[raddr1] ? wdata : regs_ext[raddr1];
    rdata2_d = wen_ext[raddr2] ? wdata : regs_ext[raddr2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              we    = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [AW-1:0]     raddr1 = '0;
  logic [AW-1:0]     raddr2 = '0;
  logic [DW-1:0]     rdata1;
  logic [DW-1:0]     rdata2;
  logic [NR*DW-1:0]  regs_flat;

  int tests  = 0;
  int failed = 0;

  register_file #(
    .DATA_W   (DW),
    .NUM_REGS (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .regs_flat (regs_flat)
  );

  always #5 clk = ~clk;

  function automatic cpu_pkg::reg_word_t slice(input int i);
    return regs_flat[DW*i +: DW];
  endfunction

  task automatic check(input string tag, input cpu_pkg::reg_word_t obs,
                       input cpu_pkg::reg_word_t exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_flat_zero(input string tag);
    logic [NR*DW-1:0] zero;
    zero = '0;
    tests++;
    assert (regs_flat === zero) else begin
      failed++;
      $error("FAIL %s: observed %h expected all zero", tag, regs_flat);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cpu_pkg::reg_word_t r0_exp;
`ifdef REG0_ZERO_EN
    r0_exp = 32'h0000_0000;
`else
    r0_exp = 32'hFFFF_FFFF;
`endif

    // Assert reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_flat_zero("reset_flat");
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);

    // Writes while reset is held are lost.
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_AAAA;
    tick();
    tick();
    check("write_in_reset", slice(9), 32'h0);

    // First edge after release takes the write.
    #2 rst_n = 1'b1;
    we = 1'b1; waddr = 5'd20; wdata = 32'd24;
    tick();
    check("first_write_flat20", slice(20), 32'd24);
    check("reset_write_lost_r9", slice(9), 32'h0);

    // Registered read of r20.
    we = 1'b0; raddr1 = 5'd20;
    tick();
    check("read_r20", rdata1, 32'd24);

    // Same-edge write forwarded to port 2; port 1 reads an untouched register.
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_1234; raddr2 = 5'd7;
    tick();
    check("bypass_rdata2", rdata2, 32'h0000_1234);
    check("bypass_rdata1_other", rdata1, 32'd24);
    check("bypass_flat7", slice(7), 32'h0000_1234);

    // Write elsewhere does not disturb a read of r7.
    we = 1'b1; waddr = 5'd8; wdata = 32'h5555_0000; raddr1 = 5'd7;
    tick();
    check("no_bypass_rdata1", rdata1, 32'h0000_1234);
    check("flat8", slice(8), 32'h5555_0000);

    // Register 0: hardwired or ordinary depending on build.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    tick();
    check("r0_same_edge", rdata1, r0_exp);
    we = 1'b0;
    tick();
    check("r0_read", rdata1, r0_exp);
    check("r0_flat", slice(0), r0_exp);

    // Last write wins on r31.
    we = 1'b1; waddr = 5'd31; wdata = 32'd10;
    tick();
    check("r31_first", slice(31), 32'd10);
    wdata = 32'd30;
    tick();
    check("r31_second", slice(31), 32'd30);
    we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd31;
    tick();
    check("lww_rdata1", rdata1, 32'd30);
    check("lww_rdata2", rdata2, 32'd30);

    // we=0 leaves r3 alone.
    we = 1'b0; waddr = 5'd3; wdata = 32'd99; raddr1 = 5'd3;
    tick();
    check("we0_rdata1", rdata1, 32'h0);
    check("we0_flat3", slice(3), 32'h0);

    // Mid-cycle reset clears everything immediately.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd31;
    tick();
    check("pre_reset_r5", rdata1, 32'hDEAD_BEEF);
    check("pre_reset_r31", rdata2, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check_flat_zero("async_reset_flat");
    check("async_reset_rdata1", rdata1, 32'h0);
    check("async_reset_rdata2", rdata2, 32'h0);
    #1 rst_n = 1'b1;

    // Fresh write after reset, both ports on the same address.
    we = 1'b1; waddr = 5'd12; wdata = 32'h0BAD_F00D; raddr1 = 5'd12; raddr2 = 5'd12;
    tick();
    check("post_reset_rdata1", rdata1, 32'h0BAD_F00D);
    check("post_reset_rdata2", rdata2, 32'h0BAD_F00D);
    check("post_reset_r5", slice(5), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each register.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count; ADDR_W = clog2(NUM_REGS) = 5.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port we, input, 1, write enable.
REQ-006 SHALL have port waddr, input, ADDR_W, write address.
REQ-007 SHALL have port wdata, input, DATA_W, write data.
REQ-008 SHALL have port raddr1, input, ADDR_W, read address, port 1.
REQ-009 SHALL have port raddr2, input, ADDR_W, read address, port 2.
REQ-010 SHALL have port rdata1, output, DATA_W, registered read data, port 1.
REQ-011 SHALL have port rdata2, output, DATA_W, registered read data, port 2.
REQ-012 SHALL have port regs_flat, output, NUM_REGS*DATA_W, every register's current contents; bits [DATA_W*i +: DATA_W] carry register i, for direct connection to the downstream 32:1 select mux inputs din0..din31.

Function
REQ-013 SHALL write wdata into register waddr on the rising clk edge when we=1; no write when we=0.
REQ-014 SHALL update regs_flat combinationally from register state; the new value is visible in the same cycle as the write edge.
REQ-015 SHALL load rdata1/rdata2 on each rising edge with register raddr1/raddr2, giving one-cycle read latency.
REQ-016 SHALL bypass a simultaneous write: if we=1 and raddrN==waddr at an edge, rdataN SHALL load wdata, not the old value.
REQ-017 SHALL allow both read ports to use the same address; each returns identical data.
REQ-018 SHALL define back-to-back writes to one address as last-write-wins, one write per cycle.
REQ-019 SHALL ignore addresses >= NUM_REGS when NUM_REGS < 2**ADDR_W: writes are dropped and reads return 0.

Reset
REQ-020 SHALL clear all registers, rdata1 and rdata2 to 0 while rst_n=0, independent of clk.
REQ-021 SHALL ignore we while rst_n=0, so a write coincident with reset assertion is lost.
REQ-022 SHALL accept the first write and read on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL support macro REG0_ZERO_EN.
- Defined: register 0 is hardwired to 0; writes to address 0 are discarded; reads and regs_flat slice 0 always return 0; bypass never applies to address 0.
- Undefined: register 0 behaves as an ordinary register.

Structure
REQ-024 SHALL place DATA_W, ADDR_W and NUM_REGS defaults, plus typedef reg_word_t (DATA_W bits), in shared package cpu_pkg.
REQ-025 SHALL implement the write-address decode as sub-module regfile_wdec (ADDR_W-to-NUM_REGS one-hot decoder, gated by we).

Verification
REQ-026 SHALL cover reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle -> regs_flat, rdata1 and rdata2 are all 0 immediately, before the next clk edge.
REQ-027 SHALL cover write then read: we=1, waddr=20, wdata=24; next cycle raddr1=20 -> rdata1=24 one edge later; regs_flat slice 20 = 24.
REQ-028 SHALL cover bypass: we=1, waddr=7, wdata=0x1234, raddr2=7 on the same edge -> rdata2=0x1234 after that edge.
REQ-029 SHALL cover REG0_ZERO_EN: write 0xFFFFFFFF to address 0, read raddr1=0 -> rdata1=0 with the macro defined, 0xFFFFFFFF without it.
REQ-030 SHALL cover last-write-wins: write 10 then 30 to r31 on consecutive edges, then read both ports at 31 -> rdata1=rdata2=30.
REQ-031 SHALL cover we=0: wdata=99, waddr=3 -> r3 is unchanged (0 after reset).
